// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Brief    : Decode-side hazard scheduler for the 16-bit 5-stage pipeline:
//            destination scoreboard, stall/flush generation, EX bypass selects.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter bit FORWARDING       = 1'b1,
    parameter bit RF_WRITE_THROUGH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [15:0] id_instruction,
    input  logic        id_branch_en,
    output logic        stall,
    output logic        flush,
    output logic [1:0]  ex_fwd_sel_a,
    output logic [1:0]  ex_fwd_sel_b,
    output logic [15:0] stall_count
);

    localparam logic [3:0]  c_OP_LD     = 4'b1010;
    localparam logic [3:0]  c_OP_ST     = 4'b1011;
    localparam logic [3:0]  c_OP_BZ     = 4'b1100;
    localparam logic [1:0]  c_SEL_RF    = 2'b00;
    localparam logic [1:0]  c_SEL_EXMEM = 2'b01;
    localparam logic [1:0]  c_SEL_MEMWB = 2'b10;
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    typedef struct packed {
        logic       valid;
        logic [2:0] addr;
        logic       is_load;
    } sb_entry_t;

    sb_entry_t r_ex, r_mem, r_wb;
    logic      r_flush_q;

    logic [3:0] w_op;
    logic [2:0] w_rd, w_rs1, w_rs2, w_src_b;
    logic       w_has_dest, w_use_a, w_use_b;
    logic       w_eff_valid;
    logic       w_a_ex, w_a_mem, w_a_wb, w_b_ex, w_b_mem, w_b_wb;
    logic       w_enter;
    logic [1:0] w_sel_a, w_sel_b;
    logic       w_unused_bits;

    assign w_op  = id_instruction[15:12];
    assign w_rd  = id_instruction[11:9];
    assign w_rs1 = id_instruction[8:6];
    assign w_rs2 = id_instruction[5:3];

    always_comb begin
        w_has_dest = 1'b0;
        w_use_a    = 1'b0;
        w_use_b    = 1'b0;
        w_src_b    = w_rs2;
        if (w_op >= 4'd1 && w_op <= 4'd8) begin
            w_has_dest = 1'b1;
            w_use_a    = 1'b1;
            w_use_b    = 1'b1;
        end else if (w_op == c_OP_LD) begin
            w_has_dest = 1'b1;
            w_use_a    = 1'b1;
        end else if (w_op == c_OP_ST) begin
            // Store data register travels on operand B
            w_use_a    = 1'b1;
            w_use_b    = 1'b1;
            w_src_b    = w_rd;
        end else if (w_op == c_OP_BZ) begin
            w_use_a    = 1'b1;
        end
    end

    // The instruction in ID right after a taken branch is already squashed
    assign w_eff_valid = id_valid & ~r_flush_q;

    function automatic logic hit(input sb_entry_t e, input logic [2:0] src);
        return e.valid && (e.addr == src);
    endfunction

    assign w_a_ex  = w_eff_valid & w_use_a & hit(r_ex,  w_rs1);
    assign w_a_mem = w_eff_valid & w_use_a & hit(r_mem, w_rs1);
    assign w_a_wb  = w_eff_valid & w_use_a & hit(r_wb,  w_rs1);
    assign w_b_ex  = w_eff_valid & w_use_b & hit(r_ex,  w_src_b);
    assign w_b_mem = w_eff_valid & w_use_b & hit(r_mem, w_src_b);
    assign w_b_wb  = w_eff_valid & w_use_b & hit(r_wb,  w_src_b);

    always_comb begin
        stall = 1'b0;
        if (FORWARDING)
            stall = (w_a_ex | w_b_ex) & r_ex.is_load;
        else
            stall = w_a_ex | w_b_ex | w_a_mem | w_b_mem;
        if (!RF_WRITE_THROUGH)
            stall = stall | w_a_wb | w_b_wb;
    end

    assign flush   = w_eff_valid & id_branch_en & ~stall;
    assign w_enter = w_eff_valid & ~stall;

    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (!FORWARDING)
            return c_SEL_RF;
        if (ex_hit && !r_ex.is_load)
            return c_SEL_EXMEM;
        if (mem_hit)
            return c_SEL_MEMWB;
        return c_SEL_RF;
    endfunction

    assign w_sel_a = w_enter ? fwd_sel(w_a_ex, w_a_mem) : c_SEL_RF;
    assign w_sel_b = w_enter ? fwd_sel(w_b_ex, w_b_mem) : c_SEL_RF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex         <= '0;
            r_mem        <= '0;
            r_wb         <= '0;
            r_flush_q    <= 1'b0;
            ex_fwd_sel_a <= c_SEL_RF;
            ex_fwd_sel_b <= c_SEL_RF;
            stall_count  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_enter && w_has_dest)
                r_ex <= '{valid: 1'b1, addr: w_rd, is_load: (w_op == c_OP_LD)};
            else
                r_ex <= '0;
            ex_fwd_sel_a <= w_sel_a;
            ex_fwd_sel_b <= w_sel_b;
            if (stall && stall_count != c_CNT_MAX)
                stall_count <= stall_count + 16'd1;
            r_flush_q <= flush;
        end
    end

    assign w_unused_bits = &{1'b0, id_instruction[2:0], r_mem.is_load, r_wb.is_load};

endmodule
`default_nettype wire
